riscv_imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the fetch/decode path reads.
- Accepts a byte stream over a valid/ready link and assembles little-endian 32-bit instruction words.
- Writes each word into imem, verifies a trailing XOR checksum, and holds the core in reset until the image has loaded cleanly.

---
 rtl/riscv_imem_loader_if.sv | 23 ++
 rtl/riscv_imem_loader.sv | 149 ++++++++++++++
 tb/tb_riscv_imem_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_imem_loader_if.sv
// rtl/riscv_imem_loader_if.sv - byte-stream ingress and imem write port of the loader
`timescale 1ns/1ps
interface riscv_imem_loader_if #(
    parameter int I_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [I_WIDTH-1:0]    imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/riscv_imem_loader.sv
// rtl/riscv_imem_loader.sv - boot-time loader: length-prefixed byte stream to imem words with XOR check
`timescale 1ns/1ps
module riscv_imem_loader #(
    parameter int I_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    riscv_imem_loader_if.slave    bus,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0]           DEPTH = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [16:0]           word_idx_q, word_idx_d;
    logic [23:0]           shift_q, shift_d;
    logic [7:0]            csum_q, csum_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [I_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;

    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = bus.rx_valid && rx_ready_q;
    assign len_full = {bus.rx_data, len_q[7:0]};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = bus.rx_data;
                    csum_d     = csum_q ^ bus.rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ bus.rx_data;
                    if ({1'b0, len_full} > DEPTH) state_d = S_ERR;
                    else if (len_full == 16'd0)   state_d = S_CSUM;
                    else                          state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {bus.rx_data, shift_q[23:8]};
                    // Fourth byte completes the word: little-endian, so it lands in the top lane.
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = BASE + word_idx_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = I_WIDTH'({bus.rx_data, shift_q});
                        word_idx_d   = word_idx_q + 17'd1;
                        if (word_idx_q + 17'd1 == {1'b0, len_q}) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
        rx_ready_d   = (state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM});
        busy_d       = rx_ready_d;
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        core_rst_n_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            rx_ready_q   <= rx_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_rst_n     = core_rst_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
endmodule

// File: tb/tb_riscv_imem_loader.sv
// tb/tb_riscv_imem_loader.sv - self-checking bench for riscv_imem_loader (two parameterisations)
`timescale 1ns/1ps
module tb_riscv_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_v, valid_v;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    riscv_imem_loader_if #(.I_WIDTH(32), .ADDR_WIDTH(10)) if_a ();
    riscv_imem_loader_if #(.I_WIDTH(32), .ADDR_WIDTH(4))  if_b ();
    assign if_a.rx_data  = rx_data;
    assign if_a.rx_valid = valid_v[0];
    assign if_b.rx_data  = rx_data;
    assign if_b.rx_valid = valid_v[1];

    logic [1:0] core_rst_n_v, busy_v, done_v, error_v, rdy, we;
    logic [15:0] waddr [2];
    logic [31:0] wdata [2];

    riscv_imem_loader #(.I_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bus(if_a.slave),
        .core_rst_n(core_rst_n_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]));
    riscv_imem_loader #(.I_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bus(if_b.slave),
        .core_rst_n(core_rst_n_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]));

    assign rdy      = {if_b.rx_ready, if_a.rx_ready};
    assign we       = {if_b.imem_we, if_a.imem_we};
    assign waddr[0] = 16'(if_a.imem_addr);
    assign waddr[1] = 16'(if_b.imem_addr);
    assign wdata[0] = if_a.imem_wdata;
    assign wdata[1] = if_b.imem_wdata;

    typedef struct { int d; int addr; logic [31:0] data; int due; } wr_t;
    typedef struct { int d; int addr; logic [31:0] data; } wl_t;

    int   depth_v [2] = '{1024, 16};
    int   base_v  [2] = '{16, 0};
    wr_t  expq [$];
    wl_t  wlog [$];
    int   idx_q [$];
    logic [1:0] exp_busy, exp_done, exp_err;
    bit   exp_we;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), 32'(busy_v[d]), 32'(exp_busy[d]));
            chk($sformatf("rx_ready%0d", d), 32'(rdy[d]), 32'(exp_busy[d]));
            chk($sformatf("done%0d", d), 32'(done_v[d]), 32'(exp_done[d]));
            chk($sformatf("error%0d", d), 32'(error_v[d]), 32'(exp_err[d]));
            chk($sformatf("core_rst_n%0d", d), 32'(core_rst_n_v[d]), 32'(exp_done[d]));
            idx_q  = expq.find_first_index(item) with (item.d == d);
            exp_we = (idx_q.size() > 0) && (expq[idx_q[0]].due == cyc);
            chk($sformatf("imem_we%0d", d), 32'(we[d]), 32'(exp_we));
            if (we[d]) wlog.push_back('{d, int'(waddr[d]), wdata[d]});
            if (exp_we && we[d]) begin
                chk($sformatf("imem_addr%0d", d), 32'(waddr[d]), 32'(expq[idx_q[0]].addr));
                chk($sformatf("imem_wdata%0d", d), wdata[d], expq[idx_q[0]].data);
            end
            if (idx_q.size() > 0 && expq[idx_q[0]].due <= cyc) expq.delete(idx_q[0]);
        end
    end

    task automatic put_byte(input int d, input logic [7:0] b);
        int w = 0;
        rx_data    = b;
        valid_v[d] = 1'b1;
        @(negedge clk);
        while (!rdy[d] && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[d]) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout dut=%0d actual=0 required=1", d);
        end
        @(posedge clk);
        #1;
        valid_v[d] = 1'b0;
    endtask

    task automatic do_start(input int d);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d]  = 1'b0;
        exp_busy[d] = 1'b1;
        exp_done[d] = 1'b0;
        exp_err[d]  = 1'b0;
    endtask

    // Model: the frame's own length field decides which bytes complete words and which byte ends it.
    task automatic send_frame(input int d, input logic [7:0] fr[$], input int max_gap, input int nbytes);
        int n, term, last, g;
        bit ovf;
        logic [7:0] x;
        n    = int'({fr[1], fr[0]});
        ovf  = n > depth_v[d];
        term = ovf ? 1 : 2 + 4 * n;
        x    = 8'h00;
        for (int i = 0; i < term; i++) x ^= fr[i];
        last = (nbytes < term + 1) ? nbytes - 1 : term;
        for (int i = 0; i <= last; i++) begin
            g = $urandom_range(max_gap, 0);
            repeat (g) begin
                rx_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            put_byte(d, fr[i]);
            if (!ovf && i >= 2 && i < term && ((i - 2) % 4) == 3)
                expq.push_back('{d, (base_v[d] + (i - 2) / 4) % depth_v[d],
                                 {fr[i], fr[i-1], fr[i-2], fr[i-3]}, cyc});
            if (i == term) begin
                exp_busy[d] = 1'b0;
                if (!ovf && fr[term] == x) exp_done[d] = 1'b1;
                else                       exp_err[d]  = 1'b1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] f1[$], f1bad[$], f2[$], fovf[$], fz[$], fb[$], fdb[$];
        logic [7:0] x;
        f1    = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        f1bad = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        f2    = '{8'h02, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00, 8'h93, 8'h82, 8'h52, 8'h00, 8'hF4};
        fovf  = '{8'h11, 8'h00};
        fz    = '{8'h00, 8'h00, 8'h00};
        fdb   = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        fb    = '{8'h10, 8'h00};
        for (int w = 0; w < 16; w++) begin
            fb.push_back(8'(w)); fb.push_back(8'h5A); fb.push_back(8'(255 - w)); fb.push_back(8'h80);
        end
        x = 8'h00;
        foreach (fb[i]) x ^= fb[i];
        fb.push_back(x);

        rst_n = 1'b0; start_v = '0; valid_v = '0; rx_data = '0;
        exp_busy = '0; exp_done = '0; exp_err = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_core_rst_n_a", 32'(core_rst_n_v[0]), 32'h0);
        chk("reset_rx_ready_b", 32'(rdy[1]), 32'h0);
        chk("reset_imem_addr_a", 32'(waddr[0]), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word on the 16-deep instance (base 0).
        wlog.delete();
        do_start(1); send_frame(1, f1, 0, 99);
        @(negedge clk);
        chk("single_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("single_addr", 32'(wlog[0].addr), 32'h0);
            chk("single_wdata", wlog[0].data, 32'h00000013);
        end
        chk("single_done", 32'(done_v[1]), 32'h1);
        chk("single_core_rst_n", 32'(core_rst_n_v[1]), 32'h1);
        chk("single_busy", 32'(busy_v[1]), 32'h0);

        // Two words with gaps on the base-0x10 instance.
        @(posedge clk); #1; wlog.delete();
        do_start(0); send_frame(0, f2, 3, 99);
        @(negedge clk);
        chk("two_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() > 1) begin
            chk("two_addr0", 32'(wlog[0].addr), 32'h10);
            chk("two_wdata0", wlog[0].data, 32'h000002B7);
            chk("two_addr1", 32'(wlog[1].addr), 32'h11);
            chk("two_wdata1", wlog[1].data, 32'h00528293);
        end
        chk("two_done", 32'(done_v[0]), 32'h1);

        // Bad checksum, then recovery.
        @(posedge clk); #1;
        do_start(1); send_frame(1, f1bad, 1, 99);
        @(negedge clk);
        chk("badcs_error", 32'(error_v[1]), 32'h1);
        chk("badcs_done", 32'(done_v[1]), 32'h0);
        chk("badcs_core_rst_n", 32'(core_rst_n_v[1]), 32'h0);
        chk("badcs_rx_ready", 32'(rdy[1]), 32'h0);
        @(posedge clk); #1;
        do_start(1); send_frame(1, f1, 2, 99);
        @(negedge clk);
        chk("recover_done", 32'(done_v[1]), 32'h1);

        // Length overflow (17 > 16) and the exact-depth and empty boundaries.
        @(posedge clk); #1; wlog.delete();
        do_start(1); send_frame(1, fovf, 0, 99);
        @(negedge clk);
        chk("ovf_error", 32'(error_v[1]), 32'h1);
        chk("ovf_rx_ready", 32'(rdy[1]), 32'h0);
        repeat (3) @(negedge clk);
        chk("ovf_nwrites", 32'(wlog.size()), 32'd0);
        @(posedge clk); #1; wlog.delete();
        do_start(1); send_frame(1, fb, 1, 999);
        @(negedge clk);
        chk("full_done", 32'(done_v[1]), 32'h1);
        chk("full_nwrites", 32'(wlog.size()), 32'd16);
        if (wlog.size() == 16) begin
            chk("full_last_addr", 32'(wlog[15].addr), 32'd15);
            chk("full_last_wdata", wlog[15].data, 32'h80F05A0F);
        end
        @(posedge clk); #1; wlog.delete();
        do_start(1); send_frame(1, fz, 0, 99);
        @(negedge clk);
        chk("zero_done", 32'(done_v[1]), 32'h1);
        chk("zero_nwrites", 32'(wlog.size()), 32'd0);

        // Reset after the second data byte.
        @(posedge clk); #1; wlog.delete();
        do_start(0); send_frame(0, f2, 0, 4);
        #2;
        rst_n = 1'b0;
        exp_busy = '0; exp_done = '0; exp_err = '0;
        #1;
        chk("midrst_busy", 32'(busy_v[0]), 32'h0);
        chk("midrst_rx_ready", 32'(rdy[0]), 32'h0);
        chk("midrst_imem_we", 32'(we[0]), 32'h0);
        chk("midrst_done_b", 32'(done_v[1]), 32'h0);
        chk("midrst_wdata", wdata[0], 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(0); send_frame(0, f2, 2, 99);
        @(negedge clk);
        chk("postrst_nwrites", 32'(wlog.size()), 32'd2);
        chk("postrst_done", 32'(done_v[0]), 32'h1);

        // Restart from DONE overwrites from the base address.
        @(posedge clk); #1; wlog.delete();
        do_start(0);
        @(negedge clk);
        chk("restart_core_rst_n", 32'(core_rst_n_v[0]), 32'h0);
        chk("restart_busy", 32'(busy_v[0]), 32'h1);
        chk("restart_done", 32'(done_v[0]), 32'h0);
        send_frame(0, fdb, 1, 99);
        @(negedge clk);
        chk("restart_done_final", 32'(done_v[0]), 32'h1);
        chk("restart_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("restart_addr", 32'(wlog[0].addr), 32'h10);
            chk("restart_wdata", wlog[0].data, 32'hDEADBEEF);
        end

        repeat (4) @(negedge clk);
        chk("pending_writes", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
